// File: rtl/gs_pkg.sv
// Shared constants, state encoding and small helpers for the GS mixer.
package gs_pkg;

  localparam int FRAME_LEN = 64;
  localparam int FC_W      = $clog2(FRAME_LEN);
  localparam int N_CH      = 4;
  localparam int SMP_W     = 8;
  localparam int VOL_W     = 6;
  localparam int GAIN_W    = 7;
  localparam int PROD_W    = 14;
  localparam int MIX_W     = 15;
  localparam int ACC_W     = MIX_W + 1;
  localparam int MUL_STEPS = GAIN_W;

  localparam logic [MIX_W-1:0] MIX_MID = 15'h4000;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    MUL  = 3'd2,
    SUM  = 3'd3,
    OUT  = 3'd4
  } state_t;

  // Full-scale volume 63 is promoted to unity gain 64.
  function automatic logic [GAIN_W-1:0] vol_to_gain(input logic [VOL_W-1:0] vol);
    return (vol == 6'd63) ? 7'd64 : {1'b0, vol};
  endfunction

  // Offset-binary sample to two's complement, sign-extended to product width.
  function automatic logic [PROD_W-1:0] dac_to_signed(input logic [SMP_W-1:0] dac);
    return {{(PROD_W-SMP_W){~dac[SMP_W-1]}}, ~dac[SMP_W-1], dac[SMP_W-2:0]};
  endfunction

  // Channel routing: map 0 puts ch0/ch1 left; map 1 puts ch0/ch3 left.
  function automatic logic ch_is_left(input int ch_map, input logic [1:0] ch);
    if (ch_map == 0) return (ch < 2'd2);
    return (ch == 2'd0) || (ch == 2'd3);
  endfunction

endpackage

// File: rtl/gs_sdm.sv
// First-order sigma-delta modulator: the accumulator carry is the bitstream.
module gs_sdm
  import gs_pkg::*;
(
  input  logic             clk32,
  input  logic             rst_n,
  input  logic [MIX_W-1:0] i_mix,
  output logic             o_sd
);

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_acc_next;

  // Drop the previous carry, then add the held mix level.
  assign w_acc_next = {1'b0, r_acc[MIX_W-1:0]} + {1'b0, i_mix};

  // Accumulator register; its top bit is the registered output bit.
  always_ff @(posedge clk32 or negedge rst_n) begin
    if (!rst_n) r_acc <= '0;
    else        r_acc <= w_acc_next;
  end

  assign o_sd = r_acc[ACC_W-1];

endmodule

// File: rtl/gs_mixer.sv
// Four-channel GS mixer: per-frame snapshot, one serial multiplier shared by
// all channels, stereo summation and sigma-delta output per side.
module gs_mixer
  import gs_pkg::*;
#(
  parameter int CH_MAP = 0
) (
  input  logic             clk32,
  input  logic             rst_n,
  input  logic             en,
  input  logic [7:0]       dac0,
  input  logic [7:0]       dac1,
  input  logic [7:0]       dac2,
  input  logic [7:0]       dac3,
  input  logic [5:0]       vol0,
  input  logic [5:0]       vol1,
  input  logic [5:0]       vol2,
  input  logic [5:0]       vol3,
  output logic [14:0]      mix_l,
  output logic [14:0]      mix_r,
  output logic             mix_stb,
  output logic             sd_l,
  output logic             sd_r
);

  logic [FC_W-1:0]   r_frame_cnt;
  state_t            r_state;
  state_t            w_state_next;
  logic [SMP_W-1:0]  r_dac [N_CH];
  logic [VOL_W-1:0]  r_vol [N_CH];
  logic [SMP_W-1:0]  w_dac_in [N_CH];
  logic [VOL_W-1:0]  w_vol_in [N_CH];
  logic [1:0]        r_ch;
  logic [2:0]        r_bit;
  logic [PROD_W-1:0] r_mcand;
  logic [PROD_W-1:0] r_prod;
  logic [GAIN_W-1:0] r_mplier;
  logic [PROD_W-1:0] w_prod_step;
  logic [MIX_W-1:0]  w_prod_ext;
  logic [MIX_W-1:0]  r_sum_l;
  logic [MIX_W-1:0]  r_sum_r;
  logic [MIX_W-1:0]  r_mix_l;
  logic [MIX_W-1:0]  r_mix_r;
  logic              r_mix_stb;
  logic              w_snap;
  logic              w_last_step;

  assign w_dac_in[0] = dac0;
  assign w_dac_in[1] = dac1;
  assign w_dac_in[2] = dac2;
  assign w_dac_in[3] = dac3;
  assign w_vol_in[0] = vol0;
  assign w_vol_in[1] = vol1;
  assign w_vol_in[2] = vol2;
  assign w_vol_in[3] = vol3;

  assign w_snap      = (r_frame_cnt == '0);
  assign w_last_step = (r_state == MUL) && (r_bit == 3'(MUL_STEPS - 1));
  assign w_prod_step = r_mplier[0] ? (r_prod + r_mcand) : r_prod;
  assign w_prod_ext  = {w_prod_step[PROD_W-1], w_prod_step};

  // Free-running frame counter; wraps every FRAME_LEN cycles.
  always_ff @(posedge clk32 or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) r_frame_cnt <= '0;
    else        r_frame_cnt <= r_frame_cnt + 1'b1;
  end

  // Capture all channel inputs once per frame; a disabled mixer captures silence.
  always_ff @(posedge clk32 or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this small snapshot array is flops, not RAM, so it is reset
      // explicitly to give a defined silent state after reset.
      for (int i = 0; i < N_CH; i++) begin
        r_dac[i] <= '0;
        r_vol[i] <= '0;
      end
    end else if (w_snap) begin
      for (int i = 0; i < N_CH; i++) begin
        r_dac[i] <= en ? w_dac_in[i] : 8'h80;
        r_vol[i] <= en ? w_vol_in[i] : '0;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk32 or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // FSM next-state: one LOAD plus seven MUL cycles per channel, then SUM, OUT.
  always_comb begin
    // NOTE: default first so every path assigns the output and no latch is inferred.
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_snap) w_state_next = LOAD;
      LOAD:    w_state_next = MUL;
      MUL:     if (w_last_step) w_state_next = (r_ch == 2'd3) ? SUM : LOAD;
      SUM:     w_state_next = OUT;
      OUT:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Shift-add multiplier and per-side accumulation of finished products.
  always_ff @(posedge clk32 or negedge rst_n) begin
    if (!rst_n) begin
      r_ch     <= '0;
      r_bit    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_sum_l  <= '0;
      r_sum_r  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_snap) begin
            r_ch    <= '0;
            r_sum_l <= '0;
            r_sum_r <= '0;
          end
        end
        LOAD: begin
          r_mcand  <= dac_to_signed(r_dac[r_ch]);
          r_mplier <= vol_to_gain(r_vol[r_ch]);
          r_prod   <= '0;
          r_bit    <= '0;
        end
        MUL: begin
          r_prod   <= w_prod_step;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_bit    <= r_bit + 1'b1;
          if (w_last_step) begin
            if (ch_is_left(CH_MAP, r_ch)) r_sum_l <= r_sum_l + w_prod_ext;
            else                          r_sum_r <= r_sum_r + w_prod_ext;
            r_ch <= r_ch + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Publish the mix (signed sum re-centred on MIX_MID) with a one-cycle strobe.
  always_ff @(posedge clk32 or negedge rst_n) begin
    if (!rst_n) begin
      r_mix_l   <= MIX_MID;
      r_mix_r   <= MIX_MID;
      r_mix_stb <= 1'b0;
    end else begin
      r_mix_stb <= (r_state == SUM);
      if (r_state == SUM) begin
        r_mix_l <= r_sum_l + MIX_MID;
        r_mix_r <= r_sum_r + MIX_MID;
      end
    end
  end

  assign mix_l   = r_mix_l;
  assign mix_r   = r_mix_r;
  assign mix_stb = r_mix_stb;

  gs_sdm u_sdm_l (
    .clk32 (clk32),
    .rst_n (rst_n),
    .i_mix (r_mix_l),
    .o_sd  (sd_l)
  );

  gs_sdm u_sdm_r (
    .clk32 (clk32),
    .rst_n (rst_n),
    .i_mix (r_mix_r),
    .o_sd  (sd_r)
  );

endmodule

// File: tb/tb_gs_mixer.sv
// Directed, table-driven bench for gs_mixer, both channel maps side by side.
module tb_gs_mixer;

  logic        clk32 = 1'b0;
  logic        rst_n = 1'b0;
  logic        en;
  logic [7:0]  dac0, dac1, dac2, dac3;
  logic [5:0]  vol0, vol1, vol2, vol3;
  logic [14:0] mix_l0, mix_r0, mix_l1, mix_r1;
  logic        stb0, stb1, sd_l0, sd_r0, sd_l1, sd_r1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic [7:0]  d0, d1, d2, d3;
    logic [5:0]  v0, v1, v2, v3;
    logic        en;
    logic [14:0] l0, r0, l1, r1;
  } vec_t;

  vec_t vecs [8];

  gs_mixer #(.CH_MAP(0)) u_dut0 (
    .clk32(clk32), .rst_n(rst_n), .en(en),
    .dac0(dac0), .dac1(dac1), .dac2(dac2), .dac3(dac3),
    .vol0(vol0), .vol1(vol1), .vol2(vol2), .vol3(vol3),
    .mix_l(mix_l0), .mix_r(mix_r0), .mix_stb(stb0), .sd_l(sd_l0), .sd_r(sd_r0)
  );

  gs_mixer #(.CH_MAP(1)) u_dut1 (
    .clk32(clk32), .rst_n(rst_n), .en(en),
    .dac0(dac0), .dac1(dac1), .dac2(dac2), .dac3(dac3),
    .vol0(vol0), .vol1(vol1), .vol2(vol2), .vol3(vol3),
    .mix_l(mix_l1), .mix_r(mix_r1), .mix_stb(stb1), .sd_l(sd_l1), .sd_r(sd_r1)
  );

  always #16 clk32 = ~clk32;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string nm,
                              input logic [7:0] d0, d1, d2, d3,
                              input logic [5:0] v0, v1, v2, v3, input logic e,
                              input logic [14:0] l0, r0, l1, r1);
    vec_t v;
    v.name = nm; v.d0 = d0; v.d1 = d1; v.d2 = d2; v.d3 = d3;
    v.v0 = v0; v.v1 = v1; v.v2 = v2; v.v3 = v3; v.en = e;
    v.l0 = l0; v.r0 = r0; v.l1 = l1; v.r1 = r1;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    dac0 = v.d0; dac1 = v.d1; dac2 = v.d2; dac3 = v.d3;
    vol0 = v.v0; vol1 = v.v1; vol2 = v.v2; vol3 = v.v3;
    en   = v.en;
  endtask

  // Wait (bounded) for the next strobe; n = negedges waited.
  task automatic wait_stb(output int n);
    n = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk32);
      if (stb0) begin
        n = k;
        break;
      end
    end
    if (n == 0) begin
      total++;
      bad++;
      $display("FAIL stb_timeout: no mix_stb within 200 cycles");
    end
  endtask

  // Called with rst_n just released at a negedge: observe the first 40 cycles.
  task automatic after_release(output int first, output int len, output logic [3:0] pat);
    first = -1; len = 0; pat = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk32);
      if (k <= 4) pat[k-1] = sd_l0;
      if (stb0) begin
        if (first < 0) first = k;
        len++;
      end
    end
  endtask

  task automatic count_ones(input int cycles, output int ones_l, output int ones_r);
    ones_l = 0; ones_r = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk32);
      ones_l += int'(sd_l0);
      ones_r += int'(sd_r0);
    end
  endtask

  initial begin
    int n, first, len, ol, or_;
    logic [3:0] pat;

    vecs[0] = mk("silence",   8'h80, 8'h80, 8'h80, 8'h80, 63, 63, 63, 63, 1'b1,
                 15'h4000, 15'h4000, 15'h4000, 15'h4000);
    vecs[1] = mk("ch0_full",  8'hFF, 8'h80, 8'h80, 8'h80, 63, 63, 63, 63, 1'b1,
                 15'h5FC0, 15'h4000, 15'h5FC0, 15'h4000);
    vecs[2] = mk("ch1_full",  8'h80, 8'hFF, 8'h80, 8'h80, 63, 63, 63, 63, 1'b1,
                 15'h5FC0, 15'h4000, 15'h4000, 15'h5FC0);
    vecs[3] = mk("extremes",  8'h00, 8'h00, 8'hFF, 8'hFF, 63, 63, 63, 63, 1'b1,
                 15'h0000, 15'h7F80, 15'h3FC0, 15'h3FC0);
    vecs[4] = mk("half_vol",  8'hC0, 8'h80, 8'h80, 8'h80, 32, 0, 0, 0, 1'b1,
                 15'h4800, 15'h4000, 15'h4800, 15'h4000);
    vecs[5] = mk("disabled",  8'hFF, 8'h00, 8'hFF, 8'h00, 63, 63, 63, 63, 1'b0,
                 15'h4000, 15'h4000, 15'h4000, 15'h4000);
    vecs[6] = mk("mixed",     8'h90, 8'h70, 8'h01, 8'hFE, 10, 5, 62, 1, 1'b1,
                 15'h4050, 15'h21BC, 15'h411E, 15'h20EE);
    vecs[7] = mk("vol62",     8'hFF, 8'h80, 8'h80, 8'h80, 62, 63, 63, 63, 1'b1,
                 15'h5EC2, 15'h4000, 15'h5EC2, 15'h4000);

    apply(vecs[0]);

    // Reset state.
    repeat (3) @(negedge clk32);
    check("rst_mix_l", mix_l0, 15'h4000);
    check("rst_mix_r", mix_r0, 15'h4000);
    check("rst_stb",   stb0, 0);
    check("rst_sd_l",  sd_l0, 0);
    check("rst_sd_r",  sd_r0, 0);

    // First frame after release: strobe latency, width and SDM start pattern.
    rst_n = 1'b1;
    after_release(first, len, pat);
    check("first_stb_cycle", first, 34);
    check("first_stb_len",   len, 1);
    check("sd_l_pattern",    pat, 4'b1010);
    check("first_mix_l",     mix_l0, 15'h4000);
    check("first_mix_r",     mix_r0, 15'h4000);

    // Table: apply right after a strobe, compare at the next strobe.
    foreach (vecs[i]) begin
      wait_stb(n);
      apply(vecs[i]);
      wait_stb(n);
      check({vecs[i].name, "_period"}, n, 64);
      check({vecs[i].name, "_m0_l"}, mix_l0, vecs[i].l0);
      check({vecs[i].name, "_m0_r"}, mix_r0, vecs[i].r0);
      check({vecs[i].name, "_m1_l"}, mix_l1, vecs[i].l1);
      check({vecs[i].name, "_m1_r"}, mix_r1, vecs[i].r1);
    end

    // Ones density for 0x4800 (36/64) and 0x4000 (32/64).
    wait_stb(n);
    apply(vecs[4]);
    wait_stb(n);
    repeat (70) @(negedge clk32);
    count_ones(64, ol, or_);
    check("density_l_4800", ol, 36);
    check("density_r_4000", or_, 32);

    // Bottom of range: left stream stays at 0.
    wait_stb(n);
    apply(vecs[3]);
    wait_stb(n);
    repeat (2) @(negedge clk32);
    count_ones(64, ol, or_);
    check("density_l_0000", ol, 0);

    // Input change at frame_cnt 5 is ignored until the next snapshot.
    wait_stb(n);
    apply(vecs[0]);
    repeat (35) @(negedge clk32);
    dac0 = 8'hFF;
    wait_stb(n);
    check("midframe_latency", n, 29);
    check("midframe_cur_l",   mix_l0, 15'h4000);
    wait_stb(n);
    check("midframe_next_l",  mix_l0, 15'h5FC0);

    // en low only around the snapshot still silences the whole frame.
    wait_stb(n);
    en = 1'b0;
    repeat (31) @(negedge clk32);
    en = 1'b1;
    wait_stb(n);
    check("en_snap_l", mix_l0, 15'h4000);
    wait_stb(n);
    check("pre_reset_l", mix_l0, 15'h5FC0);

    // Asynchronous reset at frame_cnt 20, then restart.
    repeat (50) @(negedge clk32);
    rst_n = 1'b0;
    #1;
    check("async_rst_mix_l",  mix_l0, 15'h4000);
    check("async_rst_mix_l1", mix_l1, 15'h4000);
    check("async_rst_stb",    stb0, 0);
    check("async_rst_sd_r",   sd_r0, 0);
    repeat (3) @(negedge clk32);
    rst_n = 1'b1;
    after_release(first, len, pat);
    check("restart_stb_cycle", first, 34);
    check("restart_stb_len",   len, 1);
    check("restart_sd_pat",    pat, 4'b1010);
    check("restart_mix_l",     mix_l0, 15'h5FC0);
    check("restart_stb1",      stb1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
